// File: rtl/block_dispatch_rr_if.sv
`default_nettype none
// ============================================================================
//  Module   : block_dispatch_rr_if
//  Purpose  : Bundles the kernel-control and per-core dispatch signals of
//             block_dispatch_rr.
//  Ports    : slave  - the dispatcher (takes start/abort/thread_count,
//                      core_enable, core_done; drives core_* outputs and
//                      busy/done/blocks_completed)
//             master - the host/core side (drives and observes the opposite
//                      directions)
//  Revision : 1.0 - initial release
// ============================================================================
interface block_dispatch_rr_if #(
    parameter int NUM_CORES         = 4,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int TC_W              = 16
);
    localparam int CTW = $clog2(THREADS_PER_BLOCK) + 1;

    logic                      start;
    logic                      abort;
    logic [TC_W-1:0]           thread_count;
    logic [NUM_CORES-1:0]      core_enable;
    logic [NUM_CORES-1:0]      core_done;
    logic [NUM_CORES-1:0]      core_start;
    logic [NUM_CORES-1:0]      core_reset;
    logic [NUM_CORES*TC_W-1:0] core_block_id;
    logic [NUM_CORES*CTW-1:0]  core_thread_count;
    logic                      busy;
    logic                      done;
    logic [TC_W-1:0]           blocks_completed;

    modport slave (
        input  start, abort, thread_count, core_enable, core_done,
        output core_start, core_reset, core_block_id, core_thread_count,
               busy, done, blocks_completed
    );

    modport master (
        output start, abort, thread_count, core_enable, core_done,
        input  core_start, core_reset, core_block_id, core_thread_count,
               busy, done, blocks_completed
    );
endinterface
`default_nettype wire

// File: rtl/block_dispatch_rr.sv
`default_nettype none
// ============================================================================
//  Module   : block_dispatch_rr
//  Purpose  : Splits a kernel of thread_count threads into blocks of
//             THREADS_PER_BLOCK threads and hands them out round-robin to
//             the enabled, free compute cores, one grant per cycle.
//  Ports    : clk   - single clock, rising edge
//             reset - synchronous, active-low
//             bus   - block_dispatch_rr_if.slave (kernel control, per-core
//                     start/reset/block id/thread count, status)
//  Revision : 1.0 - initial release
// ============================================================================
module block_dispatch_rr #(
    parameter int NUM_CORES         = 4,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int TC_W              = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    block_dispatch_rr_if.slave  bus
);
    localparam int CTW        = $clog2(THREADS_PER_BLOCK) + 1;
    localparam int c_log2_tpb = $clog2(THREADS_PER_BLOCK);
    localparam int c_pw       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [CTW-1:0]  c_tpb = CTW'(THREADS_PER_BLOCK);
    localparam logic [TC_W:0]   c_one = (TC_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [TC_W-1:0]           r_tc, w_tc_nxt;
    logic [TC_W:0]             r_dispatched, w_dispatched_nxt;
    logic [TC_W-1:0]           r_completed, w_completed_nxt;
    logic [c_pw-1:0]           r_ptr, w_ptr_nxt;
    // A core is BUSY exactly while its core_start is high.
    logic [NUM_CORES-1:0]      r_core_start, w_core_start_nxt;
    logic [NUM_CORES-1:0]      r_core_reset, w_core_reset_nxt;
    logic [NUM_CORES*TC_W-1:0] r_block_id, w_block_id_nxt;
    logic [NUM_CORES*CTW-1:0]  r_thread_cnt, w_thread_cnt_nxt;

    logic [TC_W:0]             w_total;
    logic [CTW-1:0]            w_last_cnt;
    logic                      w_start_ok;
    logic                      w_abort_ok;
    logic [NUM_CORES-1:0]      w_comp;
    logic [NUM_CORES-1:0]      w_eligible;
    logic                      w_can_dispatch;
    logic [TC_W-1:0]           w_done_cnt;
    logic                      w_grant_vld;
    logic [c_pw-1:0]           w_grant_idx;
    logic [c_pw-1:0]           w_scan;

    // One extra bit so an all-ones thread_count cannot wrap the rounding add.
    assign w_total    = ({1'b0, r_tc} + (TC_W+1)'(THREADS_PER_BLOCK - 1)) >> c_log2_tpb;
    // Threads left over for the final block (1..THREADS_PER_BLOCK).
    assign w_last_cnt = CTW'({1'b0, r_tc} - ((w_total - c_one) << c_log2_tpb));

    assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_abort_ok = bus.abort && ((r_state == S_INIT) || (r_state == S_RUN));
    // core_done only counts for cores that currently hold a block.
    assign w_comp     = (r_state == S_RUN) ? (bus.core_done & r_core_start) : '0;
    // A completing core is still BUSY this cycle, so it cannot be re-granted.
    assign w_eligible = ~r_core_start & bus.core_enable;
    assign w_can_dispatch = (r_state == S_RUN) && !w_abort_ok && (r_dispatched < w_total);

    // Round-robin search starting at r_ptr (the core after the last grant).
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan      = '0;
        w_done_cnt  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_scan = c_pw'((int'(r_ptr) + k) % NUM_CORES);
            if (w_can_dispatch && !w_grant_vld && w_eligible[w_scan]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan;
            end
            w_done_cnt = w_done_cnt + TC_W'(w_comp[k]);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt      = r_state;
        w_tc_nxt         = r_tc;
        w_dispatched_nxt = r_dispatched;
        w_completed_nxt  = r_completed;
        w_ptr_nxt        = r_ptr;
        w_core_start_nxt = r_core_start;
        w_core_reset_nxt = '0;
        w_block_id_nxt   = r_block_id;
        w_thread_cnt_nxt = r_thread_cnt;

        case (r_state)
            S_IDLE, S_DONE: if (w_start_ok) w_state_nxt = S_INIT;
            S_INIT: begin
                if (w_abort_ok)             w_state_nxt = S_IDLE;
                else if (w_total == '0)     w_state_nxt = S_DONE;
                else                        w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_abort_ok)                          w_state_nxt = S_IDLE;
                else if ({1'b0, r_completed} >= w_total) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_start_ok) begin
            w_tc_nxt         = bus.thread_count;
            w_dispatched_nxt = '0;
            w_completed_nxt  = '0;
            w_ptr_nxt        = '0;
            w_core_start_nxt = '0;
            w_core_reset_nxt = '1;
        end else if (w_abort_ok) begin
            // blocks_completed deliberately survives an abort.
            w_core_start_nxt = '0;
            w_core_reset_nxt = '1;
        end else if (r_state == S_RUN) begin
            w_core_start_nxt = r_core_start & ~w_comp;
            w_core_reset_nxt = w_comp;
            w_completed_nxt  = r_completed + w_done_cnt;
            if (w_grant_vld) begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (w_grant_idx == c_pw'(i)) begin
                        w_core_start_nxt[i]             = 1'b1;
                        w_block_id_nxt[i*TC_W +: TC_W]  = r_dispatched[TC_W-1:0];
                        w_thread_cnt_nxt[i*CTW +: CTW]  =
                            (r_dispatched == (w_total - c_one)) ? w_last_cnt : c_tpb;
                    end
                end
                w_dispatched_nxt = r_dispatched + c_one;
                w_ptr_nxt = (w_grant_idx == c_pw'(NUM_CORES - 1)) ? '0 : (w_grant_idx + c_pw'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_tc         <= '0;
            r_dispatched <= '0;
            r_completed  <= '0;
            r_ptr        <= '0;
            r_core_start <= '0;
            r_core_reset <= '1;
            r_block_id   <= '0;
            r_thread_cnt <= {NUM_CORES{c_tpb}};
        end else begin
            r_state      <= w_state_nxt;
            r_tc         <= w_tc_nxt;
            r_dispatched <= w_dispatched_nxt;
            r_completed  <= w_completed_nxt;
            r_ptr        <= w_ptr_nxt;
            r_core_start <= w_core_start_nxt;
            r_core_reset <= w_core_reset_nxt;
            r_block_id   <= w_block_id_nxt;
            r_thread_cnt <= w_thread_cnt_nxt;
        end
    end

    assign bus.core_start        = r_core_start;
    assign bus.core_reset        = r_core_reset;
    assign bus.core_block_id     = r_block_id;
    assign bus.core_thread_count = r_thread_cnt;
    assign bus.busy              = (r_state == S_INIT) || (r_state == S_RUN);
    assign bus.done              = (r_state == S_DONE);
    assign bus.blocks_completed  = r_completed;
endmodule
`default_nettype wire

// File: tb/tb_block_dispatch_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_block_dispatch_rr
//  Purpose  : Self-checking bench for block_dispatch_rr. A driver issues
//             directed and random kernels; a monitor keeps a behavioural
//             model (integer counters, a block queue) and checks the DUT
//             every cycle, popping expected blocks as cores start.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_block_dispatch_rr;
    localparam int NC  = 4;
    localparam int TPB = 4;
    localparam int TCW = 16;
    localparam int CTW = $clog2(TPB) + 1;

    typedef struct { int id; int cnt; } blk_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    block_dispatch_rr_if #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .TC_W(TCW)) bus ();

    block_dispatch_rr #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .TC_W(TCW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit auto_done = 1'b0;
    bit rand_en   = 1'b0;

    blk_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor + reference model ----------------
    initial begin : monitor
        int m_mode;      // 0 idle, 1 init, 2 run, 3 done
        int m_total, m_disp, m_comp, m_last;
        bit [NC-1:0] m_busy, fin, elig;
        bit reached;
        logic [NC-1:0] e_reset, prev_start;
        logic [TCW-1:0] e_id [NC];
        logic [CTW-1:0] e_cnt [NC];
        logic [NC*TCW-1:0] e_id_flat;
        logic [NC*CTW-1:0] e_cnt_flat;
        bit m_valid;
        blk_t blk;
        int tc, c;

        m_mode = 0; m_total = 0; m_disp = 0; m_comp = 0; m_last = NC - 1;
        m_busy = '0; e_reset = '1; prev_start = '0; m_valid = 1'b0;
        for (int i = 0; i < NC; i++) begin e_id[i] = '0; e_cnt[i] = CTW'(TPB); end
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("core_start", 64'(bus.core_start), 64'(m_busy));
                check("core_reset", 64'(bus.core_reset), 64'(e_reset));
                check("busy", 64'(bus.busy), 64'((m_mode == 1) || (m_mode == 2)));
                check("done", 64'(bus.done), 64'(m_mode == 3));
                check("blocks_completed", 64'(bus.blocks_completed), 64'(m_comp));
                for (int i = 0; i < NC; i++) begin
                    if (bus.core_start[i] && !prev_start[i]) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL dispatch_unexpected: core %0d started, expected no pending block", i);
                        end else begin
                            blk = exp_q.pop_front();
                            check("dispatch_block_id", 64'(bus.core_block_id[i*TCW +: TCW]), 64'(blk.id));
                            check("dispatch_thread_count", 64'(bus.core_thread_count[i*CTW +: CTW]), 64'(blk.cnt));
                            e_id[i]  = TCW'(blk.id);
                            e_cnt[i] = CTW'(blk.cnt);
                        end
                    end
                end
                for (int i = 0; i < NC; i++) begin
                    e_id_flat[i*TCW +: TCW]  = e_id[i];
                    e_cnt_flat[i*CTW +: CTW] = e_cnt[i];
                end
                check("core_block_id_hold", 64'(bus.core_block_id), 64'(e_id_flat));
                check("core_thread_count_hold", 64'(bus.core_thread_count), 64'(e_cnt_flat));
            end
            prev_start = bus.core_start;

            // Predict the next cycle from the inputs the DUT samples next edge.
            if (!reset) begin
                m_mode = 0; m_busy = '0; m_comp = 0; m_disp = 0; m_last = NC - 1;
                e_reset = '1; exp_q.delete();
                for (int i = 0; i < NC; i++) begin e_id[i] = '0; e_cnt[i] = CTW'(TPB); end
            end else if (bus.start && (m_mode == 0 || m_mode == 3)) begin
                tc = int'(bus.thread_count);
                m_total = (tc + TPB - 1) / TPB;
                m_disp = 0; m_comp = 0; m_busy = '0; m_last = NC - 1;
                e_reset = '1; m_mode = 1;
                exp_q.delete();
                for (int b = 0; b < m_total; b++)
                    exp_q.push_back('{id: b, cnt: (b == m_total - 1) ? tc - b * TPB : TPB});
            end else if (bus.abort && (m_mode == 1 || m_mode == 2)) begin
                m_busy = '0; e_reset = '1; m_mode = 0; exp_q.delete();
            end else if (m_mode == 1) begin
                e_reset = '0;
                m_mode = (m_total == 0) ? 3 : 2;
            end else if (m_mode == 2) begin
                fin = m_busy & bus.core_done;
                e_reset = fin;
                reached = (m_comp >= m_total);
                m_comp += $countones(fin);
                if (m_disp < m_total) begin
                    elig = ~m_busy & bus.core_enable;
                    for (int k = 1; k <= NC; k++) begin
                        c = (m_last + k) % NC;
                        if (elig[c]) begin
                            m_busy[c] = 1'b1; m_last = c; m_disp++;
                            break;
                        end
                    end
                end
                m_busy &= ~fin;
                if (reached) m_mode = 3;
            end else begin
                e_reset = '0;
            end
            m_valid = 1'b1;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (auto_done)
            for (int i = 0; i < NC; i++)
                bus.core_done[i] = bus.core_start[i] ? ($urandom_range(0, 3) == 0)
                                                     : ($urandom_range(0, 9) == 0);
        if (rand_en && ($urandom_range(0, 7) == 0)) bus.core_enable = NC'($urandom);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic launch(input int tc);
        bus.thread_count = TCW'(tc);
        bus.start = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        int c = 0;
        while (bus.busy && c < max_cycles) begin tick(); c++; end
        n_checks++;
        if (bus.busy) begin
            n_err++;
            $display("FAIL %s_timeout: busy=%0b after %0d cycles, expected 0", tag, bus.busy, c);
        end
    endtask

    initial begin : watchdog
        #(900000);
        n_err++;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus.start = 1'b0; bus.abort = 1'b0; bus.thread_count = '0;
        bus.core_enable = '1; bus.core_done = '0;
        ticks(3);
        check("reset_core_reset", 64'(bus.core_reset), 64'({NC{1'b1}}));
        check("reset_busy", 64'(bus.busy), 64'(0));
        reset = 1'b1;
        ticks(2);

        // 10 threads over 4-thread blocks: counts 4/4/2 to cores 0/1/2.
        auto_done = 1'b1;
        launch(10);
        wait_idle(500, "k10");
        check("k10_done", 64'(bus.done), 64'(1));
        check("k10_blocks", 64'(bus.blocks_completed), 64'(3));

        // Cores 1 and 3 finishing in the same cycle.
        auto_done = 1'b0; bus.core_done = '0;
        launch(16);
        ticks(5);
        bus.core_done = 4'b1010; tick();
        bus.core_done = 4'b0000; ticks(2);
        bus.core_done = 4'b0101; tick();
        bus.core_done = 4'b0000;
        wait_idle(50, "simul");
        check("simul_blocks", 64'(bus.blocks_completed), 64'(4));

        // Empty kernel.
        launch(0);
        wait_idle(10, "empty");
        check("empty_done", 64'(bus.done), 64'(1));
        check("empty_no_start", 64'(bus.core_start), 64'(0));

        // Only core 2 enabled.
        auto_done = 1'b1; bus.core_enable = 4'b0100;
        launch(12);
        wait_idle(500, "single");
        check("single_blocks", 64'(bus.blocks_completed), 64'(3));
        bus.core_enable = '1;

        // Abort after two of five blocks complete.
        auto_done = 1'b0; bus.core_done = '0;
        launch(20);
        ticks(5);
        bus.core_done = 4'b0011; tick();
        bus.core_done = 4'b0000;
        bus.abort = 1'b1; tick();
        check("abort_blocks", 64'(bus.blocks_completed), 64'(2));
        check("abort_reset", 64'(bus.core_reset), 64'(4'b1111));
        ticks(2);
        auto_done = 1'b1;
        launch(20);
        wait_idle(500, "restart");

        // Start during RUN is ignored.
        launch(30);
        ticks(3);
        bus.thread_count = TCW'(5); bus.start = 1'b1; tick();
        wait_idle(500, "ign_start");
        check("ign_start_blocks", 64'(bus.blocks_completed), 64'(8));

        // Reset in the middle of a run.
        launch(30);
        ticks(5);
        reset = 1'b0; tick();
        reset = 1'b1; ticks(3);

        // Random kernels with wandering enables and occasional aborts.
        rand_en = 1'b1;
        for (int it = 0; it < 25; it++) begin
            bus.core_enable = NC'($urandom_range(1, 15));
            launch($urandom_range(0, 50));
            if ($urandom_range(0, 4) == 0) begin
                ticks($urandom_range(2, 15));
                bus.abort = 1'b1; tick();
            end
            wait_idle(3000, "rand");
            ticks($urandom_range(0, 3));
        end
        rand_en = 1'b0; auto_done = 1'b0; bus.core_done = '0;
        ticks(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/block_dispatch_rr.md
BLOCK_DISPATCH_RR -- requirements
Module: block_dispatch_rr

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of compute cores served.
REQ-002 SHALL have parameter THREADS_PER_BLOCK, default 4, threads per block; power of two, 1..128.
REQ-003 SHALL have parameter TC_W, default 16, width of the thread count and the block counters.
REQ-004 SHALL define CTW = $clog2(THREADS_PER_BLOCK)+1 as the per-core thread-count width.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port start  in  1  one-cycle kernel launch pulse.
REQ-008 SHALL have port abort  in  1  one-cycle kernel cancel pulse.
REQ-009 SHALL have port thread_count  in  TC_W  total threads of the kernel; sampled on accepted start.
REQ-010 SHALL have port core_enable  in  NUM_CORES  per-core eligibility mask for new blocks.
REQ-011 SHALL have port core_done  in  NUM_CORES  per-core block-finished level.
REQ-012 SHALL have port core_start  out  NUM_CORES  per-core block-valid level.
REQ-013 SHALL have port core_reset  out  NUM_CORES  per-core one-cycle reset pulse.
REQ-014 SHALL have port core_block_id  out  NUM_CORES*TC_W  flattened block ids; core i at [i*TC_W +: TC_W].
REQ-015 SHALL have port core_thread_count  out  NUM_CORES*CTW  flattened thread counts; core i at [i*CTW +: CTW].
REQ-016 SHALL have port busy  out  1  high in INIT and RUN.
REQ-017 SHALL have port done  out  1  sticky kernel-complete flag.
REQ-018 SHALL have port blocks_completed  out  TC_W  running count of finished blocks.

Function
REQ-019 SHALL implement states IDLE, INIT, RUN, DONE.
REQ-020 SHALL compute total_blocks = ceil(thread_count/THREADS_PER_BLOCK) at TC_W+1 bits without overflow, from the latched thread_count.
REQ-021 SHALL accept start only in IDLE or DONE: latch thread_count, clear done, blocks_completed and the dispatch counter, go to INIT; start in INIT/RUN is ignored.
REQ-022 SHALL in INIT assert core_reset on all cores for exactly one cycle, then go to RUN, or to DONE if total_blocks==0.
REQ-023 SHALL track each core as FREE or BUSY; INIT leaves all cores FREE.
REQ-024 SHALL in RUN dispatch at most one block per cycle while dispatched < total_blocks.
REQ-025 SHALL grant round-robin among cores that are FREE and core_enable-high, searching from the index after the last granted core (core 0 first after start).
REQ-026 SHALL on a grant in cycle N assert core_start[i] from N+1, with core_block_id = dispatch counter and core_thread_count = THREADS_PER_BLOCK; for the final block it is thread_count-(total_blocks-1)*THREADS_PER_BLOCK (range 1..THREADS_PER_BLOCK).
REQ-027 SHALL hold core_start[i], core_block_id[i] and core_thread_count[i] stable while core i is BUSY.
REQ-028 SHALL sample core_done[i] only while core_start[i] is high; core_done of FREE cores is ignored.
REQ-029 SHALL on core_done[i] in cycle N set core_start[i]=0 and core_reset[i]=1 in N+1, return core i to FREE in N+1, and permit its next core_start no earlier than N+2.
REQ-030 SHALL add the popcount of all same-cycle completions to blocks_completed; no simultaneous completion is lost.
REQ-031 SHALL allow a grant and completions in the same cycle, on different cores.
REQ-032 SHALL never re-grant a core in the cycle its completion is sampled.
REQ-033 SHALL let a BUSY core whose core_enable drops finish its block; it receives no further grants while disabled.
REQ-034 SHALL stay in RUN with busy=1 while no core is enabled; there is no timeout.
REQ-035 SHALL go to DONE the cycle after blocks_completed reaches total_blocks; done=1 and busy=0 hold until the next accepted start or reset.
REQ-036 SHALL on abort in INIT or RUN, in the next cycle: clear all core_start, pulse core_reset on all cores for one cycle, go to IDLE with done=0, and keep blocks_completed.
REQ-037 SHALL ignore abort in IDLE and DONE.
REQ-038 SHALL give abort priority over a same-cycle completion or grant.

Reset
REQ-039 SHALL while reset==0 force state IDLE; busy=0, done=0, blocks_completed=0, core_start=0, core_reset all ones, core_block_id=0, core_thread_count=THREADS_PER_BLOCK; all cores FREE; round-robin pointer to core 0.
REQ-040 SHALL deassert core_reset in the first cycle after reset returns high.
REQ-041 SHALL take reset over start and abort in the same cycle; reset mid-kernel discards all progress.

Verification
REQ-042 SHALL be verified with NUM_CORES=4, TPB=4, thread_count=10: blocks 0/1/2 to cores 0/1/2 on consecutive cycles, counts 4/4/2; done=1 after 3 completions.
REQ-043 SHALL be verified with cores 1 and 3 raising core_done in the same cycle: blocks_completed increments by 2, and both cores pulse core_reset the next cycle.
REQ-044 SHALL be verified with thread_count=0: INIT then DONE, done=1 two cycles after start, no core_start.
REQ-045 SHALL be verified with core_enable=4'b0100 and thread_count=12: all 3 blocks go to core 2 serially, at least 2 cycles between core_done and the next core_start.
REQ-046 SHALL be verified with abort after 2 of 5 blocks complete: next cycle core_start=0 and core_reset=4'b1111, state IDLE, done=0, blocks_completed=2; a new start restarts at block 0.
REQ-047 SHALL be verified with start during RUN (ignored) and reset=0 mid-RUN (all outputs at reset values next cycle).
